// File: rtl/bcd_display_driver.sv
// Binary-to-BCD converter (iterative double-dabble) feeding an 8-digit
// multiplexed 7-segment display showing hh.mm.ss on the lower six digits.
module bcd_display_driver #(
    parameter int REFRESH_DIV = 100_000,
    parameter int REFRESH_W   = $clog2(REFRESH_DIV)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] number,
    output logic [23:0] digits,
    output logic        digits_valid,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] shreg_q, shreg_d;
    logic [23:0] bcd_q, bcd_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic        sat_q, sat_d;
    logic [23:0] digits_q, digits_d;
    logic        valid_q, valid_d;

    logic [REFRESH_W-1:0] rc_q, rc_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;

    logic [23:0] bcd_adj;
    logic [31:0] dig_ext;
    logic [3:0]  nib;

    function automatic logic [23:0] add3(input logic [23:0] b);
        logic [23:0] r;
        r = b;
        for (int i = 0; i < 6; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Conversion FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = SHIFT;
            SHIFT:   state_d = (bitcnt_q == 5'd0) ? DONE : SHIFT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bcd_adj = add3(bcd_q);

    always_comb begin
        shreg_d  = shreg_q;
        bcd_d    = bcd_q;
        bitcnt_d = bitcnt_q;
        sat_d    = sat_q;
        digits_d = digits_q;
        valid_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                shreg_d  = number;
                bcd_d    = 24'h0;
                bitcnt_d = 5'd23;
                sat_d    = (number > 24'd999_999);
            end
            SHIFT: begin
                {bcd_d, shreg_d} = {bcd_adj[22:0], shreg_q, 1'b0};
                bitcnt_d = bitcnt_q - 5'd1;
            end
            DONE: begin
                digits_d = sat_q ? 24'h999999 : bcd_q;
                valid_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q  <= '0;
            bcd_q    <= '0;
            bitcnt_q <= '0;
            sat_q    <= 1'b0;
            digits_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            bcd_q    <= bcd_d;
            bitcnt_q <= bitcnt_d;
            sat_q    <= sat_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
        end
    end

    // Display scan always reads the last completed digits
    assign dig_ext = {8'h00, digits_q};
    assign nib     = dig_ext[{idx_q, 2'b00} +: 4];

    always_comb begin
        rc_d  = rc_q + REFRESH_W'(1);
        idx_d = idx_q;
        if (rc_q == REFRESH_W'(REFRESH_DIV - 1)) begin
            rc_d  = '0;
            idx_d = idx_q + 3'd1;
        end
        if (idx_q < 3'd6) begin
            an_d  = ~(8'b1 << idx_q);
            seg_d = decode(nib);
            dp_d  = ~((idx_q == 3'd2) || (idx_q == 3'd4));
        end else begin
            an_d  = 8'hFF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rc_q  <= '0;
            idx_q <= '0;
            an_q  <= 8'hFF;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            rc_q  <= rc_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign digits       = digits_q;
    assign digits_valid = valid_q;
    assign an           = an_q;
    assign seg          = seg_q;
    assign dp           = dp_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Bench for bcd_display_driver: arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_bcd_display_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] number = '0;
    logic [23:0] digits;
    logic        digits_valid;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int compared   = 0;
    int mismatched = 0;
    bit armed      = 1'b0;

    bcd_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .number       (number),
        .digits       (digits),
        .digits_valid (digits_valid),
        .an           (an),
        .seg          (seg),
        .dp           (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int unsigned n);
        logic [23:0] r;
        int unsigned v;
        v = (n > 999_999) ? 999_999 : n;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    logic [6:0] seg_tab [16];
    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    end

    // Reference model: a conversion completes every 26 cycles from the
    // value seen on the first cycle of the period.
    int          m_cyc;
    int unsigned m_cap;
    logic [23:0] m_digits;
    logic        m_valid;
    int          m_rc;
    int          m_idx;
    logic [7:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_dp;

    always @(posedge clk) begin
        if (rst) begin
            m_cyc = 0; m_cap = 0; m_digits = '0; m_valid = 1'b0;
            m_rc = 0; m_idx = 0;
            m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
        end else begin
            if (m_idx < 6) begin
                m_an  = 8'hFF & ~(8'(1) << m_idx);
                m_seg = seg_tab[(m_digits >> (4 * m_idx)) & 24'hF];
                m_dp  = (m_idx == 2 || m_idx == 4) ? 1'b0 : 1'b1;
            end else begin
                m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
            end
            if (m_rc == DIV - 1) begin
                m_rc  = 0;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_rc++;
            end
            if (m_cyc == 0) m_cap = number;
            m_valid = (m_cyc == 25);
            if (m_cyc == 25) m_digits = to_bcd(m_cap);
            m_cyc = (m_cyc + 1) % 26;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("model_digits", 32'(digits), 32'(m_digits));
            check("model_valid", 32'(digits_valid), 32'(m_valid));
            check("model_an", 32'(an), 32'(m_an));
            check("model_seg", 32'(seg), 32'(m_seg));
            check("model_dp", 32'(dp), 32'(m_dp));
        end
    end

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (digits_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("valid_timeout", 32'(ok), 32'd1);
    endtask

    logic [7:0]  an_pat [8];
    int unsigned vec_in  [5];
    logic [23:0] vec_exp [5];

    initial begin
        int first;
        bit found;
        an_pat  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFF, 8'hFF};
        vec_in  = '{0, 9, 10, 999_999, 500_005};
        vec_exp = '{24'h000000, 24'h000009, 24'h000010, 24'h999999, 24'h500005};

        rst = 1'b1;
        number = '0;
        @(negedge clk);
        armed = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        rst = 1'b0;

        first = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (digits_valid && first == 0) first = n;
            check("scan_an", 32'(an), 32'(an_pat[((n - 1) / 4) % 8]));
            check("scan_dp", 32'(dp),
                  32'((an == 8'hFB || an == 8'hEF) ? 1'b0 : 1'b1));
        end
        check("first_valid_latency", 32'(first), 32'd26);
        check("reset_digits", 32'(digits), 32'h000000);

        number = 24'd235959;
        found = 1'b0;
        for (int i = 0; i < 52; i++) begin
            @(negedge clk);
            if (digits == 24'h235959) begin
                found = 1'b1;
                break;
            end
        end
        check("hms_within_52", 32'(found), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an == 8'hFE) begin
                found = 1'b1;
                break;
            end
        end
        check("idx0_seen", 32'(found), 32'd1);
        check("idx0_seg", 32'(seg), 32'b0010000);

        number = 24'd1_000_000;
        wait_valid(); wait_valid();
        check("sat_1e6", 32'(digits), 32'h999999);
        number = 24'd16_777_215;
        wait_valid(); wait_valid();
        check("sat_max", 32'(digits), 32'h999999);

        for (int k = 0; k < 5; k++) begin
            number = 24'(vec_in[k]);
            wait_valid(); wait_valid();
            check("vector", 32'(digits), 32'(vec_exp[k]));
        end

        wait_valid();
        number = 24'd123456;
        repeat (5) @(negedge clk);
        number = 24'd654321;
        wait_valid();
        check("midchg_first", 32'(digits), 32'h123456);
        wait_valid();
        check("midchg_second", 32'(digits), 32'h654321);

        wait_valid();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_valid", 32'(digits_valid), 32'd0);
            check("midrst_digits", 32'(digits), 32'h0);
            check("midrst_an", 32'(an), 32'hFF);
        end
        rst = 1'b0;
        first = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (digits_valid) begin
                first = n;
                break;
            end
        end
        check("restart_latency", 32'(first), 32'd26);
        check("restart_digits", 32'(digits), 32'h654321);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
